mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU controller and a DMA engine share one memory.
// DMA has priority, but after DMA_BURST back-to-back DMA grants a waiting CPU gets the next slot.
module mem_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned DMA_BURST     = 4
) (
   input  logic clk,
   input  logic reset_,
   input  logic cpu_req,
   input  logic cpu_we,
   input  logic dma_req,
   input  logic dma_we,
   output logic wait_,
   output logic mem_en,
   output logic mem_we,
   output logic mem_sel,
   output logic dma_grant,
   output logic cpu_done,
   output logic dma_done
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam logic [3:0] AccLoad  = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] BurstMax = 4'(DMA_BURST);

   state_e     state_q, state_d;
   logic [3:0] acc_cnt_q, acc_cnt_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic       mem_en_q, mem_en_d;
   logic       mem_we_q, mem_we_d;
   logic       mem_sel_q, mem_sel_d;
   logic       dma_grant_q, dma_grant_d;
   logic       cpu_done_q, cpu_done_d;
   logic       dma_done_q, dma_done_d;
   logic       grant_dma;

   // CPU only overrides a requesting DMA once the burst budget is spent.
   assign grant_dma = dma_req && !(cpu_req && (burst_cnt_q == BurstMax));

   always_comb begin
      state_d     = state_q;
      acc_cnt_d   = acc_cnt_q;
      burst_cnt_d = burst_cnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_sel_d   = mem_sel_q;
      dma_grant_d = dma_grant_q;
      cpu_done_d  = 1'b0;
      dma_done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            mem_en_d    = 1'b0;
            dma_grant_d = 1'b0;
            if (cpu_req || dma_req) begin
               state_d     = StAccess;
               acc_cnt_d   = AccLoad;
               mem_en_d    = 1'b1;
               mem_sel_d   = grant_dma;
               dma_grant_d = grant_dma;
               mem_we_d    = grant_dma ? dma_we : cpu_we;
               if (grant_dma) begin
                  burst_cnt_d = (burst_cnt_q < BurstMax) ? burst_cnt_q + 4'd1 : burst_cnt_q;
               end else begin
                  burst_cnt_d = 4'd0;
               end
            end
         end
         StAccess: begin
            if (acc_cnt_q == 4'd0) begin
               state_d    = StDone;
               mem_en_d   = 1'b0;
               cpu_done_d = !mem_sel_q;
               dma_done_d = mem_sel_q;
            end else begin
               acc_cnt_d = acc_cnt_q - 4'd1;
            end
         end
         StDone: begin
            state_d     = StIdle;
            dma_grant_d = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q     <= StIdle;
         acc_cnt_q   <= 4'd0;
         burst_cnt_q <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_sel_q   <= 1'b0;
         dma_grant_q <= 1'b0;
         cpu_done_q  <= 1'b0;
         dma_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_cnt_q   <= acc_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_sel_q   <= mem_sel_d;
         dma_grant_q <= dma_grant_d;
         cpu_done_q  <= cpu_done_d;
         dma_done_q  <= dma_done_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_sel   = mem_sel_q;
   assign dma_grant = dma_grant_q;
   assign cpu_done  = cpu_done_q;
   assign dma_done  = dma_done_q;
   // Stall drops in the done cycle so the controller can finish without waiting for IDLE.
   assign wait_     = !(cpu_req && !cpu_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (ACCESS_CYCLES=2, DMA_BURST=4).
// Outputs are packed as {mem_en, mem_we, mem_sel, dma_grant, cpu_done, dma_done, wait_}.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset_, cpu_req, cpu_we, dma_req, dma_we;
   logic wait_, mem_en, mem_we, mem_sel, dma_grant, cpu_done, dma_done;
   int   nvec = 0;
   int   nerr = 0;

   // Don't-care mask outside ACCESS: mem_we and mem_sel carry no meaning there.
   localparam logic [6:0] All  = 7'b1111111;
   localparam logic [6:0] Ctrl = 7'b1001111;

   localparam logic [6:0] ACpu  = 7'b1000000;  // CPU read access, stalled
   localparam logic [6:0] ADma  = 7'b1111000;  // DMA write access, CPU stalled
   localparam logic [6:0] DCpu  = 7'b0000101;
   localparam logic [6:0] DDmaW = 7'b0001010;  // DMA done, CPU still waiting
   localparam logic [6:0] DDmaF = 7'b0001011;  // DMA done, no CPU request
   localparam logic [6:0] IWait = 7'b0000000;
   localparam logic [6:0] IFree = 7'b0000001;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ACCESS_CYCLES(2),
      .DMA_BURST    (4)
   ) dut (
      .clk      (clk),
      .reset_   (reset_),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .wait_    (wait_),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_sel  (mem_sel),
      .dma_grant(dma_grant),
      .cpu_done (cpu_done),
      .dma_done (dma_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] exp, input logic [6:0] mask);
      logic [6:0] o;
      #1;
      o = {mem_en, mem_we, mem_sel, dma_grant, cpu_done, dma_done, wait_};
      nvec++;
      assert ((o & mask) === (exp & mask))
      else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b (mask %b)", tag, o, exp, mask);
      end
   endtask

   logic [5:0] own_dma;

   initial begin
      own_dma = 6'b101111;  // bit i = 1 -> transaction i goes to DMA
      reset_ = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b1;

      // Reset held two edges with CPU requesting, then released.
      step(); step();
      chk("reset_hold", IWait, All);
      reset_ = 1'b1;
      step(); chk("reset_rel_a1", ACpu, All);
      step(); chk("reset_rel_a2", ACpu, All);
      step(); chk("reset_rel_done", DCpu, Ctrl);
      cpu_req = 1'b0;
      step(); chk("reset_rel_idle", IFree, Ctrl);

      // Lone CPU write; cpu_we flips after grant and must not leak into mem_we.
      cpu_req = 1'b1; cpu_we = 1'b1;
      chk("cpuw_stall_idle", IWait, Ctrl);
      step(); chk("cpuw_a1", 7'b1100000, All);
      cpu_we = 1'b0;
      step(); chk("cpuw_a2", 7'b1100000, All);
      step(); chk("cpuw_done", DCpu, Ctrl);
      cpu_req = 1'b0;
      step(); chk("cpuw_idle", IFree, Ctrl);

      // Contention from reset release: D,D,D,D,C,D.
      reset_ = 1'b0;
      step();
      cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b1; cpu_we = 1'b0;
      reset_ = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("cont%0d_a1", i), own_dma[i] ? ADma : ACpu, All);
         step(); chk($sformatf("cont%0d_a2", i), own_dma[i] ? ADma : ACpu, All);
         step(); chk($sformatf("cont%0d_done", i), own_dma[i] ? DDmaW : DCpu, Ctrl);
         step(); chk($sformatf("cont%0d_idle", i), IWait, Ctrl);
         step();
      end

      // DMA alone six times saturates the burst count; a late CPU request then wins.
      reset_ = 1'b0; cpu_req = 1'b0;
      step();
      reset_ = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         step(); chk($sformatf("dmaonly%0d_done", i), DDmaF, Ctrl);
         step();
         if (i == 5) cpu_req = 1'b1;
         step();
      end
      chk("sat_cpu_wins_a1", ACpu, All);
      step(); chk("sat_cpu_a2", ACpu, All);
      step(); chk("sat_cpu_done", DCpu, Ctrl);
      cpu_req = 1'b0;
      step();
      step(); chk("sat_dma_next", 7'b1111001, All);

      // Reset in the second cycle of a DMA access aborts it with no done pulse.
      step(); chk("abort_a2", 7'b1111001, All);
      reset_ = 1'b0;
      step(); chk("abort_reset", IFree, All);
      reset_ = 1'b1; dma_req = 1'b0;
      step(); chk("abort_no_done1", IFree, All);
      step(); chk("abort_no_done2", IFree, Ctrl);

      // CPU drops its request in access cycle 1; access still completes.
      cpu_req = 1'b1; cpu_we = 1'b0;
      step(); chk("drop_a1", ACpu, All);
      cpu_req = 1'b0;
      chk("drop_a1_wait", 7'b1000001, All);
      step(); chk("drop_a2", 7'b1000001, All);
      step(); chk("drop_done", DCpu, Ctrl);
      step(); chk("drop_idle", IFree, Ctrl);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
